// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: ALU op codes that select it,
// FSM state encodings and the iteration counter width.
package div_unit_pkg;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Counter must hold WIDTH-1; 6 bits covers WIDTH up to 64.
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU. Produces {remainder, quotient}
// WIDTH+1 cycles after an accepted start (1 cycle for divide by zero).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [WIDTH-1:0]     num1,
    input  logic [WIDTH-1:0]     num2,
    input  logic                 signed_div,
    input  logic                 start,
    input  logic                 cancel,
    output logic                 stall,
    output logic                 valid,
    output logic                 div_zero,
    output logic [2*WIDTH-1:0]   result,
    output logic [1:0]           fsm_state
);

    // Handshake: start is taken in the cycle it is high while IDLE and cancel
    // is low; stall stays high from that cycle until the result cycle, and
    // valid is a one-cycle pulse with result/div_zero stable alongside it.

    div_state_e           state, state_next;
    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     rem;
    logic                 neg_q;
    logic                 neg_r;

    logic                 accept;
    logic                 zero_div;
    logic                 last_step;
    logic [WIDTH-1:0]     mag1;
    logic [WIDTH-1:0]     mag2;
    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     quo_next;
    logic [WIDTH-1:0]     rem_final;
    logic [WIDTH-1:0]     quo_final;

    assign accept    = start && (state == DIV_IDLE) && !cancel;
    assign zero_div  = (num2 == '0);
    assign last_step = (state == DIV_BUSY) && (cnt == DIV_CNT_W'(WIDTH - 1));
    assign stall     = accept || (state == DIV_BUSY);
    assign fsm_state = state;

    assign mag1 = (signed_div && num1[WIDTH-1]) ? (~num1 + 1'b1) : num1;
    assign mag2 = (signed_div && num2[WIDTH-1]) ? (~num2 + 1'b1) : num2;

    // One restoring step: bring in the next dividend bit, trial-subtract.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor};
    assign q_bit     = ~diff[WIDTH];
    assign rem_next  = q_bit ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {quo[WIDTH-2:0], q_bit};

    assign rem_final = neg_r ? (~rem_next + 1'b1) : rem_next;
    assign quo_final = neg_q ? (~quo_next + 1'b1) : quo_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    state_next = zero_div ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (cancel) begin
                    state_next = DIV_IDLE;
                end else if (last_step) begin
                    state_next = DIV_DONE;
                end
            end
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (state == DIV_BUSY && !cancel && !last_step) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else if (accept) begin
            divisor <= mag2;
            quo     <= mag1;
            rem     <= '0;
            neg_q   <= signed_div && (num1[WIDTH-1] ^ num2[WIDTH-1]);
            neg_r   <= signed_div && num1[WIDTH-1];
        end else if (state == DIV_BUSY && !cancel) begin
            rem     <= rem_next;
            quo     <= quo_next;
        end
    end

    // Divide by zero reports the raw dividend, not its magnitude.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid    <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
        end else begin
            valid <= 1'b0;
            if (accept && zero_div) begin
                valid    <= 1'b1;
                div_zero <= 1'b1;
                result   <= {num1, {WIDTH{1'b1}}};
            end else if (last_step && !cancel) begin
                valid    <= 1'b1;
                div_zero <= 1'b0;
                result   <= {rem_final, quo_final};
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed MIPS cases, cancel/reset
// behaviour and a randomized run against a magnitude-division model.
module tb_div_unit;

    localparam int W = 32;

    logic            clk;
    logic            resetn;
    logic [W-1:0]    num1;
    logic [W-1:0]    num2;
    logic            signed_div;
    logic            start;
    logic            cancel;
    logic            stall;
    logic            valid;
    logic            div_zero;
    logic [2*W-1:0]  result;
    logic [1:0]      fsm_state;

    int              errors;
    int              checks;
    int              cyc;
    logic [2*W:0]    exp_q[$];
    logic [2*W-1:0]  last_res;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .num1       (num1),
        .num2       (num2),
        .signed_div (signed_div),
        .start      (start),
        .cancel     (cancel),
        .stall      (stall),
        .valid      (valid),
        .div_zero   (div_zero),
        .result     (result),
        .fsm_state  (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: divide magnitudes, then apply truncate-toward-zero signs.
    function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit s);
        logic [W-1:0] ma, mb, q, r;
        if (b == 0) return {1'b1, a, {W{1'b1}}};
        ma = (s && a[W-1]) ? -a : a;
        mb = (s && b[W-1]) ? -b : b;
        q  = ma / mb;
        r  = ma % mb;
        if (s && (a[W-1] ^ b[W-1])) q = -q;
        if (s && a[W-1]) r = -r;
        return {1'b0, r, q};
    endfunction

    // Scoreboard: every valid pops the oldest expected result.
    always @(negedge clk) begin
        if (resetn && valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                check("result", {div_zero, result}, e);
                last_res = e[2*W-1:0];
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                         input logic [2*W:0] exp, input bit now, output int c);
        if (!now) begin
            @(posedge clk);
            #1;
        end
        num1 = a;
        num2 = b;
        signed_div = s;
        start = 1'b1;
        c = cyc;
        exp_q.push_back(exp);
        @(negedge clk);
        check("stall_accept", stall, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        num1 = $urandom;
        num2 = $urandom;
        signed_div = $urandom_range(0, 1);
    endtask

    task automatic wait_valid(input int c, input int lat_exp, input bit noise, input bit chk_stall);
        bit found;
        int stall_cnt;
        found = 0;
        stall_cnt = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (valid) begin
                found = 1;
                start = 1'b0;
                check("latency", cyc - c, lat_exp);
                if (chk_stall) begin
                    check("stall_cycles", stall_cnt, lat_exp - 1);
                    check("stall_done", stall, 0);
                end
            end else begin
                if (stall) stall_cnt++;
                if (noise) start = $urandom_range(0, 1);
            end
        end
        if (!found) check("timeout", 0, 1);
        start = 1'b0;
    endtask

    initial begin
        int c;
        int c2;
        logic [W-1:0] a, b;
        bit s;

        errors = 0;
        checks = 0;
        cyc = 0;
        last_res = '0;
        resetn = 1'b0;
        num1 = '0;
        num2 = '0;
        signed_div = 1'b0;
        start = 1'b0;
        cancel = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid, 0);
        check("rst_div_zero", div_zero, 0);
        check("rst_result", result, 0);
        check("rst_state", fsm_state, 0);
        check("rst_stall", stall, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Directed MIPS cases.
        issue(32'd100, 32'd7, 1'b0, {1'b0, 32'd2, 32'd14}, 1'b0, c);
        wait_valid(c, 33, 1'b0, 1'b1);
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, c);
        wait_valid(c, 33, 1'b0, 1'b0);
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, {1'b0, 32'd1, 32'hFFFF_FFFD}, 1'b0, c);
        wait_valid(c, 33, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {1'b0, 32'd0, 32'h8000_0000}, 1'b0, c);
        wait_valid(c, 33, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {1'b0, 32'h8000_0000, 32'd0}, 1'b0, c);
        wait_valid(c, 33, 1'b0, 1'b0);
        issue(32'h1234_5678, 32'd0, 1'b0, {1'b1, 32'h1234_5678, 32'hFFFF_FFFF}, 1'b0, c);
        wait_valid(c, 1, 1'b0, 1'b1);
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, {1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b0, c);
        wait_valid(c, 1, 1'b0, 1'b0);
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, {1'b0, 32'd0, 32'hFFFF_FFFF}, 1'b0, c);
        wait_valid(c, 33, 1'b0, 1'b0);

        // Cancel mid-divide, then restart in the very next cycle.
        issue(32'd100, 32'd7, 1'b0, {1'b0, 32'd2, 32'd14}, 1'b0, c);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        cancel = 1'b0;
        check("cancel_state", fsm_state, 0);
        check("cancel_stall", stall, 0);
        check("cancel_result_held", result, last_res);
        issue(32'd9, 32'd3, 1'b0, {1'b0, 32'd0, 32'd3}, 1'b1, c2);
        check("restart_cycle", c2 - c, 11);
        wait_valid(c2, 33, 1'b1, 1'b0);

        // Cancel together with start in IDLE: nothing accepted.
        @(posedge clk);
        #1;
        num2 = 32'd5;
        start = 1'b1;
        cancel = 1'b1;
        #2;
        check("cancel_start_stall", stall, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        cancel = 1'b0;
        check("cancel_start_state", fsm_state, 0);

        // Asynchronous reset mid-operation.
        issue(32'd1000, 32'd3, 1'b0, {1'b0, 32'd1, 32'd333}, 1'b0, c);
        repeat (4) @(posedge clk);
        #3;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("arst_state", fsm_state, 0);
        check("arst_valid", valid, 0);
        check("arst_result", result, 0);
        check("arst_stall", stall, 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Randomized run, mixing back-to-back and gapped requests.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = $urandom_range(1, 15);
                2: b = '1;
                3: a = 32'h8000_0000;
                4: begin
                    a = $urandom_range(0, 255);
                    b = $urandom_range(1, 300);
                end
                default: ;
            endcase
            issue(a, b, s, model(a, b, s), 1'b0, c);
            wait_valid(c, (b == 0) ? 1 : 33, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
